// File: rtl/flappy_pkg.sv
// flappy_pkg: types and constants shared by the pipe-pattern generator and
// the pipe_scroller display stage.
//   column_t       : one 8-row display column, bit 7 = top row
//   insert_state_t : scroller insert FSM states
//   SEED_COL       : column pushed first after reset; also the generator's
//                    reset value, so both sides agree on the opening pipe
package flappy_pkg;

  typedef logic [7:0] column_t;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    GAP  = 2'd1,
    EMIT = 2'd2
  } insert_state_t;

  localparam column_t SEED_COL  = 8'b11111000;
  localparam column_t BLANK_COL = 8'h00;

endpackage

// File: rtl/pipe_scroller_scroll_tick.sv
// scroll_tick: free-running period counter with a freeze input.
// Ports:
//   clock  in  : system clock, rising edge
//   reset  in  : asynchronous active-low reset
//   hold   in  : holds the counter at zero and suppresses the wrap pulse
//   wrap   out : high in the cycle the counter sits at MAX; the counter
//                returns to zero on the closing edge of that cycle
// A wrap therefore occurs every MAX+1 cycles, counted from reset release or
// from hold deassertion.
module scroll_tick #(
  parameter int           W   = 12,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic wrap
);

  logic [W-1:0] count;

  assign wrap = (count == MAX) && !hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (hold || (count == MAX)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: shifts the generator's column pattern into an 8x8 display
// frame, right to left, one column per scroll tick, with GAP_COLS blank
// columns after every pipe column, and flags bird/pipe overlap.
// Ports:
//   clock      in  : system clock, rising edge
//   reset      in  : asynchronous active-low reset
//   lossDetect in  : freeze request; stops the tick counter, frame and FSM
//   pipe_col   in  : generator column, sampled only on EMIT shifts
//   bird_row   in  : one-hot bird row, bit 7 = top row
//   frame      out : display frame, bits [8i+7:8i] = column i, 7 rightmost
//   right      out : column 7, fed back to the generator
//   mid        out : column 4, fed back to the generator
//   shift_tick out : high in the cycle whose closing edge shifts the frame
//   collide    out : sticky, registered bird/pipe overlap at BIRD_COL
//   score      out : pipes passed, saturating; only with PIPE_SCROLLER_SCORE_EN
// Optional feature macro: PIPE_SCROLLER_SCORE_EN
//
// Insert FSM (advances only on shift edges):
//   state | meaning
//   SEED  | insert SEED_COL once after reset to kick the generator
//   GAP   | insert blank columns, GAP_COLS in a row
//   EMIT  | insert pipe_col as sampled on this shift
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter logic [11:0] TICK_MAX = 12'd2559,
  parameter int          GAP_COLS = 2,
  parameter int          BIRD_COL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lossDetect,
  input  logic [7:0]  pipe_col,
  input  logic [7:0]  bird_row,
  output logic [63:0] frame,
  output logic [7:0]  right,
  output logic [7:0]  mid,
  output logic        shift_tick,
  output logic        collide
`ifdef PIPE_SCROLLER_SCORE_EN
  ,
  output logic [7:0]  score
`endif
);

  localparam logic [2:0] GAP_LAST = 3'(GAP_COLS - 1);

  insert_state_t state, state_next;
  logic [2:0]    gap_cnt, gap_next;
  column_t       insert_col;
  column_t       bird_column;

  scroll_tick #(
    .W   (12),
    .MAX (TICK_MAX)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .hold  (lossDetect),
    .wrap  (shift_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= SEED;
      gap_cnt <= '0;
    end else if (shift_tick) begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    case (state)
      SEED: state_next = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_next   = '0;
          state_next = EMIT;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      EMIT:    state_next = GAP;
      default: state_next = SEED;
    endcase
  end

  always_comb begin
    insert_col = SEED_COL;
    case (state)
      SEED:    insert_col = SEED_COL;
      GAP:     insert_col = BLANK_COL;
      EMIT:    insert_col = pipe_col;
      default: insert_col = SEED_COL;
    endcase
  end

  // Column 7 is the top byte, so a right-to-left scroll is a right shift by
  // one byte with the new column entering at the top.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame <= '0;
    end else if (shift_tick) begin
      frame <= {insert_col, frame[63:8]};
    end
  end

  assign right       = frame[63:56];
  assign mid         = frame[39:32];
  assign bird_column = frame[8*BIRD_COL +: 8];

  // Evaluated every cycle, including while frozen, so a hit that lands on
  // the freezing shift is still reported.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      collide <= 1'b0;
    end else if (|(bird_column & bird_row)) begin
      collide <= 1'b1;
    end
  end

`ifdef PIPE_SCROLLER_SCORE_EN
  // A pipe counts as passed when it shifts out of the bird column without
  // a collision having been recorded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score <= '0;
    end else if (shift_tick && (bird_column != BLANK_COL) && !collide &&
                 (score != 8'hFF)) begin
      score <= score + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: directed bench for pipe_scroller with TICK_MAX=3,
// GAP_COLS=2, BIRD_COL=1. The expected frame is tracked by a byte-shift
// model fed from hand-written insert sequences.
// Optional feature macro: PIPE_SCROLLER_SCORE_EN (adds score checks).
module tb_pipe_scroller;

  logic        clock;
  logic        reset;
  logic        lossDetect;
  logic [7:0]  pipe_col;
  logic [7:0]  bird_row;
  logic [63:0] frame;
  logic [7:0]  right;
  logic [7:0]  mid;
  logic        shift_tick;
  logic        collide;
`ifdef PIPE_SCROLLER_SCORE_EN
  logic [7:0]  score;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mframe;
  int          cyc;
  int          mscore;

  logic [7:0] sc_ins [0:13] = '{8'hF8, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hC0,
                                8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hC0, 8'h00};

  pipe_scroller #(
    .TICK_MAX (12'd3),
    .GAP_COLS (2),
    .BIRD_COL (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .lossDetect (lossDetect),
    .pipe_col   (pipe_col),
    .bird_row   (bird_row),
    .frame      (frame),
    .right      (right),
    .mid        (mid),
    .shift_tick (shift_tick),
    .collide    (collide)
`ifdef PIPE_SCROLLER_SCORE_EN
    ,
    .score      (score)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for shift_tick at a falling edge, then samples one
  // falling edge after the shifting rising edge.
  task automatic tick_next(output int c);
    c = 0;
    while ((c < 64) && (shift_tick !== 1'b1)) begin
      @(posedge clock);
      @(negedge clock);
      c++;
    end
    if (shift_tick !== 1'b1) chk("tick_timeout", {63'd0, shift_tick}, 64'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic step(input logic [7:0] ins, input string tag);
    int c;
    tick_next(c);
    mframe = {ins, mframe[63:8]};
    chk({tag, "_frame"}, frame, mframe);
    chk({tag, "_right"}, {56'd0, right}, {56'd0, ins});
  endtask

  initial begin
    reset      = 1'b0;
    lossDetect = 1'b0;
    pipe_col   = 8'hC7;
    bird_row   = 8'b10000000;
    mframe     = '0;
    repeat (3) @(negedge clock);

    chk("rst_frame", frame, 64'd0);
    chk("rst_right", {56'd0, right}, 64'd0);
    chk("rst_mid", {56'd0, mid}, 64'd0);
    chk("rst_tick", {63'd0, shift_tick}, 64'd0);
    chk("rst_collide", {63'd0, collide}, 64'd0);
`ifdef PIPE_SCROLLER_SCORE_EN
    chk("rst_score", {56'd0, score}, 64'd0);
`endif

    reset = 1'b1;
    tick_next(cyc);
    chk("first_tick_cycles", cyc, 64'd3);
    mframe = {8'hF8, mframe[63:8]};
    chk("t1_frame", frame, mframe);
    chk("t1_right", {56'd0, right}, 64'hF8);

    step(8'h00, "t2");
    step(8'h00, "t3");
    step(8'hC7, "t4");
    chk("t4_mid", {56'd0, mid}, 64'hF8);
    step(8'h00, "t5");
    step(8'h00, "t6");
    chk("t6_collide", {63'd0, collide}, 64'd0);

    pipe_col = 8'h5A;
    step(8'h5A, "t7");
    chk("t7_collide_lag", {63'd0, collide}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk("t7_collide_set", {63'd0, collide}, 64'd1);

    pipe_col = 8'h81;
    step(8'h00, "t8");
    chk("t8_col0", {56'd0, frame[7:0]}, 64'hF8);
    step(8'h00, "t9");
    chk("t9_col0", {56'd0, frame[7:0]}, 64'h00);
    chk("t9_collide_sticky", {63'd0, collide}, 64'd1);
    step(8'h81, "t10");
    step(8'h00, "t11");
    step(8'h00, "t12");
    step(8'h81, "t13");

    cyc = 0;
    while ((cyc < 64) && (shift_tick !== 1'b1)) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    if (shift_tick !== 1'b1) chk("loss_wait_timeout", {63'd0, shift_tick}, 64'd1);
    lossDetect = 1'b1;
    #1;
    chk("loss_wins_tick", {63'd0, shift_tick}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk("loss_no_shift", frame, mframe);
    repeat (5) @(negedge clock);
    chk("loss_hold_tick", {63'd0, shift_tick}, 64'd0);
    chk("loss_hold_frame", frame, mframe);
    chk("loss_collide", {63'd0, collide}, 64'd1);

    lossDetect = 1'b0;
    tick_next(cyc);
    chk("resume_cycles", cyc, 64'd3);
    mframe = {8'h00, mframe[63:8]};
    chk("t14_frame", frame, mframe);

    step(8'h00, "t15");
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_frame", frame, 64'd0);
    chk("midrst_right", {56'd0, right}, 64'd0);
    chk("midrst_mid", {56'd0, mid}, 64'd0);
    chk("midrst_collide", {63'd0, collide}, 64'd0);
    chk("midrst_tick", {63'd0, shift_tick}, 64'd0);
`ifdef PIPE_SCROLLER_SCORE_EN
    chk("midrst_score", {56'd0, score}, 64'd0);
`endif

    bird_row = 8'b00000001;
    pipe_col = 8'hC0;
    mframe   = '0;
    mscore   = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if ((mframe[15:8] != 8'h00) && (mscore < 255)) mscore++;
      step(sc_ins[k], "sc");
`ifdef PIPE_SCROLLER_SCORE_EN
      chk("sc_score", {56'd0, score}, 64'(mscore));
`endif
    end
    chk("sc_no_collide", {63'd0, collide}, 64'd0);
`ifdef PIPE_SCROLLER_SCORE_EN
    chk("sc_score_final", {56'd0, score}, 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
